player_grid_ctrl: RTL and testbench

Grid-locked player movement controller: the parametrised successor of the fixed 32-px raccoon mover. It converts four raw direction buttons into tile steps on a configurable grid. Button handling is synchronised and edge-triggered, with auto-repeat. The block also provides respawn, a goal (top-row) sequence, freeze, and blocked-move reporting. It sits between the board button inputs and the sprite/collision logic, which consume o_X/o_Y pixel coordinates.

---
 rtl/player_pkg.sv | 22 ++
 rtl/dir_repeat.sv | 77 +++++++
 rtl/player_grid_ctrl.sv | 163 ++++++++++++++++
 tb/tb_player_grid_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared encodings for the grid-locked player controller: step directions,
// main play/goal states and the per-button repeat states.
package player_pkg;

    localparam logic [1:0] DIR_UP = 2'd0;
    localparam logic [1:0] DIR_DN = 2'd1;
    localparam logic [1:0] DIR_LT = 2'd2;
    localparam logic [1:0] DIR_RT = 2'd3;

    typedef enum logic {
        PLAY = 1'b0,
        GOAL = 1'b1
    } main_state_e;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        IDLE   = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } dir_state_e;

endpackage

// File: rtl/dir_repeat.sv
// One direction button: 2-flop synchroniser, rising-edge detect and
// auto-repeat FSM producing single-cycle fire requests.
module dir_repeat
    import player_pkg::*;
#(
    parameter int REPEAT_DELAY  = 6_000_000,
    parameter int REPEAT_PERIOD = 3_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Btn,
    input  logic       i_Lock,
    output logic       o_Fire,
    output logic [1:0] o_State
);

    localparam int MAX_LOAD = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W    = (MAX_LOAD > 0) ? $clog2(MAX_LOAD + 1) : 1;

    logic             sync1, sync2, sync3;
    dir_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             fire;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            state <= LOCKED;
            cnt   <= '0;
        end else begin
            sync1 <= i_Btn;
            sync2 <= sync1;
            sync3 <= sync2;
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // sync3 is the previous sync2 sample; IDLE only fires on a fresh press.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fire     = 1'b0;
        if (i_Lock) begin
            state_nx = LOCKED;
        end else begin
            case (state)
                LOCKED: if (!sync2) state_nx = IDLE;
                IDLE: begin
                    if (sync2 && !sync3) begin
                        fire     = 1'b1;
                        state_nx = DELAY;
                        cnt_nx   = CNT_W'(REPEAT_DELAY);
                    end
                end
                DELAY, REPEAT: begin
                    if (!sync2) begin
                        state_nx = IDLE;
                    end else if (cnt == '0) begin
                        fire     = 1'b1;
                        state_nx = REPEAT;
                        cnt_nx   = CNT_W'(REPEAT_PERIOD);
                    end else begin
                        cnt_nx = cnt - CNT_W'(1);
                    end
                end
                default: state_nx = LOCKED;
            endcase
        end
    end

    assign o_Fire  = fire;
    assign o_State = state;

endmodule

// File: rtl/player_grid_ctrl.sv
// Grid-locked player mover: arbitrates four repeating buttons into tile steps,
// handles edges, respawn, freeze, the top-row goal sequence and a step counter.
module player_grid_ctrl
    import player_pkg::*;
#(
    parameter int TILE_SIZE     = 32,
    parameter int GRID_COLS     = 20,
    parameter int GRID_ROWS     = 15,
    parameter int START_COL     = 10,
    parameter int START_ROW     = 14,
    parameter int REPEAT_DELAY  = 6_000_000,
    parameter int REPEAT_PERIOD = 3_000_000,
    parameter int GOAL_HOLD     = 25_000_000
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic                         i_Up,
    input  logic                         i_Dn,
    input  logic                         i_Lt,
    input  logic                         i_Rt,
    input  logic                         i_Respawn,
    input  logic                         i_Freeze,
    output logic [$clog2(GRID_COLS)-1:0] o_Col,
    output logic [$clog2(GRID_ROWS)-1:0] o_Row,
    output logic [9:0]                   o_X,
    output logic [9:0]                   o_Y,
    output logic                         o_Moved,
    output logic [1:0]                   o_Dir,
    output logic                         o_Blocked,
    output logic                         o_Goal,
    output logic [15:0]                  o_Moves,
    output logic [8:0]                   o_State
);

    localparam int COL_W   = $clog2(GRID_COLS);
    localparam int ROW_W   = $clog2(GRID_ROWS);
    localparam int TILE_SH = $clog2(TILE_SIZE);
    localparam int GCNT_W  = (GOAL_HOLD > 1) ? $clog2(GOAL_HOLD) : 1;

    logic [3:0]  btn, fire;
    logic [7:0]  dir_dbg;
    logic        lock;
    main_state_e state, state_nx;
    logic [GCNT_W-1:0] goal_cnt, goal_cnt_nx;
    logic [COL_W-1:0]  col_nx;
    logic [ROW_W-1:0]  row_nx;
    logic [1:0]  dir_nx, sel;
    logic [15:0] moves_q, moves_nx;
    logic        moved_nx, blocked_nx, goal_nx, hit;

    // Index order matches the direction encodings, so fire[DIR_x] is that button.
    assign btn  = {i_Rt, i_Lt, i_Dn, i_Up};
    assign lock = i_Freeze | i_Respawn | (state == GOAL);

    for (genvar g = 0; g < 4; g++) begin : g_dir
        dir_repeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_dir (
            .i_Clk  (i_Clk),
            .i_Rst  (i_Rst),
            .i_Btn  (btn[g]),
            .i_Lock (lock),
            .o_Fire (fire[g]),
            .o_State(dir_dbg[2*g +: 2])
        );
    end

    always_comb begin
        if      (fire[DIR_UP]) sel = DIR_UP;
        else if (fire[DIR_DN]) sel = DIR_DN;
        else if (fire[DIR_LT]) sel = DIR_LT;
        else                   sel = DIR_RT;
        case (sel)
            DIR_UP:  hit = (o_Row == '0);
            DIR_DN:  hit = (o_Row == ROW_W'(GRID_ROWS - 1));
            DIR_LT:  hit = (o_Col == '0);
            default: hit = (o_Col == COL_W'(GRID_COLS - 1));
        endcase
    end

    always_comb begin
        state_nx    = state;
        goal_cnt_nx = goal_cnt;
        col_nx      = o_Col;
        row_nx      = o_Row;
        dir_nx      = o_Dir;
        moves_nx    = moves_q;
        moved_nx    = 1'b0;
        blocked_nx  = 1'b0;
        goal_nx     = 1'b0;
        if (i_Respawn) begin
            col_nx   = COL_W'(START_COL);
            row_nx   = ROW_W'(START_ROW);
            state_nx = PLAY;
        end else begin
            case (state)
                PLAY: begin
                    if (|fire) begin
                        if (hit) begin
                            blocked_nx = 1'b1;
                        end else begin
                            moved_nx = 1'b1;
                            dir_nx   = sel;
                            moves_nx = (moves_q == 16'hFFFF) ? moves_q : moves_q + 16'd1;
                            case (sel)
                                DIR_UP:  row_nx = o_Row - ROW_W'(1);
                                DIR_DN:  row_nx = o_Row + ROW_W'(1);
                                DIR_LT:  col_nx = o_Col - COL_W'(1);
                                default: col_nx = o_Col + COL_W'(1);
                            endcase
                            if (sel == DIR_UP && o_Row == ROW_W'(1)) begin
                                goal_nx     = 1'b1;
                                state_nx    = GOAL;
                                goal_cnt_nx = GCNT_W'(GOAL_HOLD - 1);
                            end
                        end
                    end
                end
                GOAL: begin
                    if (goal_cnt == '0) begin
                        col_nx   = COL_W'(START_COL);
                        row_nx   = ROW_W'(START_ROW);
                        state_nx = PLAY;
                    end else begin
                        goal_cnt_nx = goal_cnt - GCNT_W'(1);
                    end
                end
                default: state_nx = PLAY;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= PLAY;
            goal_cnt  <= '0;
            o_Col     <= COL_W'(START_COL);
            o_Row     <= ROW_W'(START_ROW);
            o_Dir     <= DIR_UP;
            moves_q   <= '0;
            o_Moved   <= 1'b0;
            o_Blocked <= 1'b0;
            o_Goal    <= 1'b0;
        end else begin
            state     <= state_nx;
            goal_cnt  <= goal_cnt_nx;
            o_Col     <= col_nx;
            o_Row     <= row_nx;
            o_Dir     <= dir_nx;
            moves_q   <= moves_nx;
            o_Moved   <= moved_nx;
            o_Blocked <= blocked_nx;
            o_Goal    <= goal_nx;
        end
    end

    assign o_Moves = moves_q;
    assign o_X     = 10'(o_Col) << TILE_SH;
    assign o_Y     = 10'(o_Row) << TILE_SH;
    assign o_State = {dir_dbg, state};

endmodule

// File: tb/tb_player_grid_ctrl.sv
// Directed bench for player_grid_ctrl with short repeat/goal timings.
module tb_player_grid_ctrl;

    logic        clk = 1'b0;
    logic        rst, up, dn, lt, rt, respawn, freeze;
    logic [4:0]  col;
    logic [3:0]  row;
    logic [9:0]  x, y;
    logic        moved, blocked, goal;
    logic [1:0]  dir;
    logic [15:0] moves;
    logic [8:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    player_grid_ctrl #(
        .TILE_SIZE(32), .GRID_COLS(20), .GRID_ROWS(15),
        .START_COL(10), .START_ROW(14),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .GOAL_HOLD(3)
    ) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
        .i_Respawn(respawn), .i_Freeze(freeze),
        .o_Col(col), .o_Row(row), .o_X(x), .o_Y(y),
        .o_Moved(moved), .o_Dir(dir), .o_Blocked(blocked), .o_Goal(goal),
        .o_Moves(moves), .o_State(dbg_state)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int c, input int r, input int mv);
        chk({tag, "_col"}, 32'(col), 32'(c));
        chk({tag, "_row"}, 32'(row), 32'(r));
        chk({tag, "_moves"}, 32'(moves), 32'(mv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst = 1'b1; up = 1'b0; dn = 1'b0; lt = 1'b0; rt = 1'b0;
        respawn = 1'b0; freeze = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        chk_pos("reset", 10, 14, 0);
        chk("reset_x", 32'(x), 320);
        chk("reset_y", 32'(y), 448);
        chk("reset_dir", 32'(dir), 0);
        chk("reset_pulses", {29'd0, moved, blocked, goal}, 0);

        // Single right tap: step three edges after the first sample
        rt = 1'b1; tick(1); rt = 1'b0; tick(1);
        chk("tap_early", 32'(moved), 0);
        tick(1);
        chk("tap_moved", 32'(moved), 1);
        chk_pos("tap", 11, 14, 1);
        chk("tap_x", 32'(x), 352);
        chk("tap_dir", 32'(dir), 3);
        tick(1);
        chk("tap_pulse_end", 32'(moved), 0);

        // Hold left for 20 cycles: steps at relative edges 2,7,10,13,16,19
        lt = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick(1);
            if (i == 20) lt = 1'b0;
            chk($sformatf("hold_lt_c%0d", i), 32'(moved),
                (i == 3 || i == 8 || i == 11 || i == 14 || i == 17 || i == 20) ? 1 : 0);
        end
        chk_pos("hold_lt", 5, 14, 7);
        chk("hold_lt_dir", 32'(dir), 2);

        // Respawn back to start
        respawn = 1'b1; tick(1); respawn = 1'b0;
        chk_pos("respawn1", 10, 14, 7);
        tick(1);

        // Down from the bottom row is blocked
        dn = 1'b1; tick(1); dn = 1'b0; tick(2);
        chk("blk_pulse", 32'(blocked), 1);
        chk("blk_moved", 32'(moved), 0);
        chk("blk_dir", 32'(dir), 2);
        chk_pos("blk", 10, 14, 7);
        tick(1);
        chk("blk_pulse_end", 32'(blocked), 0);

        // Up and left together: up wins
        up = 1'b1; lt = 1'b1; tick(1); up = 1'b0; lt = 1'b0; tick(2);
        chk("prio_moved", 32'(moved), 1);
        chk("prio_dir", 32'(dir), 0);
        chk_pos("prio", 10, 13, 8);
        tick(2);
        chk_pos("prio_after", 10, 13, 8);

        // Hold up to row 0
        up = 1'b1;
        waited = 0;
        while (!(moved === 1'b1 && row == 4'd0) && waited < 100) begin
            tick(1);
            waited++;
        end
        chk("goal_reached", 32'(waited < 100), 1);
        chk("goal_pulse", 32'(goal), 1);
        chk("goal_moved", 32'(moved), 1);
        chk_pos("goal", 10, 0, 21);
        chk("goal_y", 32'(y), 0);
        tick(1);
        chk("goal_hold1_row", 32'(row), 0);
        chk("goal_hold1_pulse", {30'd0, goal, moved}, 0);
        tick(1);
        chk("goal_hold2_row", 32'(row), 0);
        tick(1);
        chk_pos("goal_return", 10, 14, 21);
        tick(6);
        chk_pos("goal_held_btn", 10, 14, 21);
        up = 1'b0;
        tick(4);
        up = 1'b1; tick(1); up = 1'b0; tick(2);
        chk_pos("after_release", 10, 13, 22);
        tick(2);

        // Respawn while right is repeating
        rt = 1'b1;
        tick(8);
        chk_pos("repeat_rt", 12, 13, 24);
        respawn = 1'b1; tick(1); respawn = 1'b0;
        chk_pos("respawn_rep", 10, 14, 24);
        tick(10);
        chk_pos("respawn_held", 10, 14, 24);
        rt = 1'b0;
        tick(3);

        // Freeze drops presses
        freeze = 1'b1;
        lt = 1'b1; tick(1); lt = 1'b0; tick(5);
        chk_pos("freeze", 10, 14, 24);
        freeze = 1'b0;
        tick(2);
        lt = 1'b1; tick(1); lt = 1'b0; tick(2);
        chk_pos("unfreeze", 9, 14, 25);
        tick(2);

        // Counter saturation
        force dut.moves_q = 16'hFFFE;
        #1 release dut.moves_q;
        tick(1);
        rt = 1'b1; tick(1); rt = 1'b0; tick(2);
        chk_pos("sat1", 10, 14, 16'hFFFF);
        tick(2);
        rt = 1'b1; tick(1); rt = 1'b0; tick(2);
        chk("sat2_moved", 32'(moved), 1);
        chk_pos("sat2", 11, 14, 16'hFFFF);

        // Reset clears the counter
        rst = 1'b1; tick(1); rst = 1'b0;
        chk_pos("rst_again", 10, 14, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
